// File: rtl/pe_out_seq.sv
// Output sequencer for a processing element: streams a job of cfg_len values either
// unchanged (pass mode) or as threshold decisions packed LSB-first into WIDTH-bit words.
module pe_out_seq #(
   parameter int WIDTH = 24,
   parameter int LEN_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    cfg_sel_bit,
   input  logic signed [WIDTH-1:0] cfg_thresh,
   input  logic        [LEN_W-1:0] cfg_len,
   output logic                    busy,
   output logic                    done,
   input  logic                    in_valid,
   input  logic signed [WIDTH-1:0] in_data,
   output logic                    in_ready,
   output logic                    out_valid,
   output logic        [WIDTH-1:0] out_data,
   output logic                    out_last,
   input  logic                    out_ready
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                    state;
   logic                      sel_bit_q;
   logic signed [WIDTH-1:0]   thresh_q;
   logic        [LEN_W-1:0]   len_q;
   logic        [LEN_W-1:0]   elem_cnt;
   logic        [WIDTH-1:0]   pack_q;
   logic        [IDX_W-1:0]   bit_idx;

   logic                      in_xfer;
   logic                      out_xfer;
   logic                      last_elem;
   logic                      word_full;
   logic        [WIDTH-1:0]   pack_nxt;

   function automatic logic [WIDTH-1:0] pack_insert(input logic [WIDTH-1:0] word,
                                                    input logic signed [WIDTH-1:0] value,
                                                    input logic signed [WIDTH-1:0] thresh,
                                                    input logic [IDX_W-1:0] pos);
      logic [WIDTH-1:0] bit_word;
      bit_word = {{(WIDTH-1){1'b0}}, (value >= thresh)};
      return word | (bit_word << pos);
   endfunction

   assign busy      = (state != IDLE);
   // A new element is only taken when the output register will be free at the edge.
   assign in_ready  = (state == RUN) && (!out_valid || out_ready);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign last_elem = (elem_cnt == (len_q - LEN_W'(1)));
   assign word_full = (bit_idx == IDX_W'(WIDTH - 1));
   assign pack_nxt  = pack_insert(pack_q, in_data, thresh_q, bit_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         sel_bit_q <= 1'b0;
         thresh_q  <= '0;
         len_q     <= '0;
         elem_cnt  <= '0;
         pack_q    <= '0;
         bit_idx   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (out_xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  sel_bit_q <= cfg_sel_bit;
                  thresh_q  <= cfg_thresh;
                  len_q     <= cfg_len;
                  elem_cnt  <= '0;
                  pack_q    <= '0;
                  bit_idx   <= '0;
                  if (cfg_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end

            RUN: begin
               if (in_xfer) begin
                  elem_cnt <= elem_cnt + LEN_W'(1);
                  if (sel_bit_q) begin
                     // Emit on a full word or on the job's final element (partial word).
                     if (word_full || last_elem) begin
                        out_valid <= 1'b1;
                        out_data  <= pack_nxt;
                        out_last  <= last_elem;
                        pack_q    <= '0;
                        bit_idx   <= '0;
                     end else begin
                        pack_q  <= pack_nxt;
                        bit_idx <= bit_idx + IDX_W'(1);
                     end
                  end else begin
                     out_valid <= 1'b1;
                     out_data  <= in_data;
                     out_last  <= last_elem;
                  end
                  if (last_elem) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (out_xfer && out_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pe_out_seq.sv
// Randomized bench for pe_out_seq against a job-level reference model of expected words.
module tb_pe_out_seq;
   localparam int WIDTH = 24;
   localparam int LEN_W = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic                    cfg_sel_bit;
   logic signed [WIDTH-1:0] cfg_thresh;
   logic        [LEN_W-1:0] cfg_len;
   logic                    busy;
   logic                    done;
   logic                    in_valid;
   logic signed [WIDTH-1:0] in_data;
   logic                    in_ready;
   logic                    out_valid;
   logic        [WIDTH-1:0] out_data;
   logic                    out_last;
   logic                    out_ready;

   int checks   = 0;
   int failures = 0;
   logic signed [WIDTH-1:0] stim[$];

   always #5 clk = ~clk;

   pe_out_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .cfg_sel_bit(cfg_sel_bit),
      .cfg_thresh (cfg_thresh),
      .cfg_len    (cfg_len),
      .busy       (busy),
      .done       (done),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Words that must exist on the output once n of len elements have been accepted.
   function automatic int n_emitted(input bit sel, input int n, input int len);
      if (!sel) return n;
      if (n == len) return (len + WIDTH - 1) / WIDTH;
      return n / WIDTH;
   endfunction

   // Called just after a falling edge; returns just after a falling edge.
   task automatic run_job(input bit sel, input logic signed [WIDTH-1:0] thr, input int len,
                          input int vprob, input int rprob, input bit stall5);
      logic [WIDTH-1:0] words[$];
      logic [WIDTH-1:0] wtmp;
      logic [WIDTH-1:0] pdata;
      logic             plast;
      int  idx = 0;
      int  nout = 0;
      int  cyc = 0;
      int  stall_cnt = 0;
      bit  seen_first = 0;
      bit  exp_done = 0;
      bit  prev_stall = 0;
      bit  fin = 0;
      bit  ev, ox, ix;

      for (int k = 0; k < len; k++) begin
         if (!sel) begin
            words.push_back(stim[k]);
         end else begin
            if (k % WIDTH == 0) words.push_back('0);
            wtmp = words[k / WIDTH];
            wtmp[k % WIDTH] = (stim[k] >= thr);
            words[k / WIDTH] = wtmp;
         end
      end

      cfg_sel_bit = sel;
      cfg_thresh  = thr;
      cfg_len     = LEN_W'(len);
      start       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      @(negedge clk);
      start       = 1'b0;
      cfg_sel_bit = 1'($urandom);
      cfg_thresh  = WIDTH'($urandom);
      cfg_len     = LEN_W'($urandom);

      if (len == 0) begin
         #1;
         chk("zero_done", done, 1);
         chk("zero_valid", out_valid, 0);
         chk("zero_busy", busy, 1);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         #1;
         chk("zero_idle_busy", busy, 0);
         chk("zero_done_low", done, 0);
         chk("zero_no_output", out_valid, 0);
         @(negedge clk);
         return;
      end

      while (!fin) begin
         if (stall5 && !seen_first && out_valid) begin
            seen_first = 1;
            stall_cnt  = 5;
         end
         in_valid = (idx < len) && ($urandom_range(99) < vprob);
         in_data  = (idx < len) ? stim[idx] : WIDTH'($urandom);
         if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
         end else begin
            out_ready = ($urandom_range(99) < rprob);
         end
         start = (idx < len) ? 1'($urandom_range(1)) : 1'b0;
         #1;
         ev = (n_emitted(sel, idx, len) > nout);
         chk("done", done, exp_done);
         chk("busy", busy, 1);
         chk("out_valid", out_valid, ev);
         chk("in_ready", in_ready, (idx < len) && (!ev || out_ready));
         if (prev_stall) begin
            chk("hold_data", out_data, pdata);
            chk("hold_last", out_last, plast);
         end
         if (out_valid && nout < words.size()) begin
            chk("out_data", out_data, words[nout]);
            chk("out_last", out_last, (nout == words.size() - 1));
         end
         if (exp_done) fin = 1;
         ox = out_valid & out_ready;
         ix = in_valid & in_ready;
         if (ox) nout++;
         if (ix) idx++;
         exp_done   = ox && (nout == words.size());
         prev_stall = out_valid && !out_ready;
         pdata      = out_data;
         plast      = out_last;
         cyc++;
         if (cyc > 3000) begin
            chk("timeout", 0, 1);
            fin = 1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      #1;
      chk("post_done_low", done, 0);
      chk("post_idle", busy, 0);
      chk("post_words", nout, words.size());
      @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      cfg_sel_bit = 1'b0;
      cfg_thresh  = '0;
      cfg_len     = '0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;

      // Pass mode, three values, always ready; start on the first edge after reset.
      stim = {24'sd5, -24'sd7, 24'sd100};
      run_job(0, 24'sd0, 3, 100, 100, 0);

      // Bit mode, alternating +1/-1 across a word boundary.
      stim = {};
      for (int k = 0; k < 26; k++) stim.push_back((k % 2 == 0) ? 24'sd1 : -24'sd1);
      run_job(1, 24'sd0, 26, 100, 100, 0);

      // Bit mode, equality and signed compare.
      stim = {24'sd10, 24'sd9, -24'sd10};
      run_job(1, 24'sd10, 3, 100, 100, 0);

      // Pass mode with a five-cycle output stall after the first word.
      stim = {24'sd11, 24'sd22, 24'sd33, 24'sd44};
      run_job(0, 24'sd0, 4, 100, 100, 1);

      // Empty job.
      stim = {};
      run_job(0, 24'sd0, 0, 100, 100, 0);

      // Reset in the middle of a five-element job.
      stim = {24'sd5, 24'sd6, 24'sd7, 24'sd8, 24'sd9};
      cfg_sel_bit = 1'b0;
      cfg_len     = LEN_W'(5);
      start       = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_data   = stim[0];
      @(negedge clk);
      in_data = stim[1];
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("mid_valid", out_valid, 1);
      chk("mid_data", out_data, 6);
      #1;
      rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_last", out_last, 0);
      chk("arst_in_ready", in_ready, 0);
      chk("arst_done", done, 0);
      @(negedge clk);
      rst  = 1'b0;
      stim = {-24'sd3, 24'sd77};
      run_job(0, 24'sd0, 2, 100, 100, 0);

      // Randomized jobs.
      for (int j = 0; j < 30; j++) begin
         int  len;
         bit  sel;
         bit  wide;
         logic signed [WIDTH-1:0] thr;
         len  = (j % 10 == 9) ? 0 : int'($urandom_range(60, 1));
         sel  = 1'($urandom_range(1));
         wide = ($urandom_range(3) == 0);
         thr  = wide ? WIDTH'($urandom) : WIDTH'($signed($urandom_range(200)) - 100);
         stim = {};
         for (int k = 0; k < len; k++) begin
            stim.push_back(wide ? WIDTH'($urandom) : WIDTH'($signed($urandom_range(255)) - 128));
         end
         run_job(sel, thr, len, int'($urandom_range(100, 40)), int'($urandom_range(100, 30)), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
